// File: rtl/morse_receiver_pkg.sv
// Shared definitions for the Morse receiver: FSM states,
// letter indices, the letter table and default timing.
package morse_defs;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    DECODE
  } state_t;

  localparam logic [2:0] LET_A = 3'd0;
  localparam logic [2:0] LET_B = 3'd1;
  localparam logic [2:0] LET_C = 3'd2;
  localparam logic [2:0] LET_D = 3'd3;
  localparam logic [2:0] LET_E = 3'd4;
  localparam logic [2:0] LET_F = 3'd5;
  localparam logic [2:0] LET_G = 3'd6;
  localparam logic [2:0] LET_H = 3'd7;

  localparam logic [27:0] DEF_TICK_DIV  = 28'd12499999;
  localparam logic [3:0]  DEF_DASH_MIN  = 4'd3;
  localparam logic [3:0]  DEF_GAP_TICKS = 4'd6;

  typedef struct packed {
    logic [2:0] count;
    logic [3:0] pattern;
    logic [2:0] index;
  } entry_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] index;
  } lookup_t;

  localparam entry_t [0:7] LETTER_TABLE = '{
    '{3'd2, 4'b0010, LET_A},
    '{3'd4, 4'b0001, LET_B},
    '{3'd4, 4'b0101, LET_C},
    '{3'd3, 4'b0001, LET_D},
    '{3'd1, 4'b0000, LET_E},
    '{3'd4, 4'b0100, LET_F},
    '{3'd3, 4'b0011, LET_G},
    '{3'd4, 4'b0000, LET_H}
  };

  function automatic lookup_t lookup(
    input logic [2:0] cnt,
    input logic [3:0] pat
  );
    lookup_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (LETTER_TABLE[i].count == cnt &&
          LETTER_TABLE[i].pattern == pat) begin
        r.hit   = 1'b1;
        r.index = LETTER_TABLE[i].index;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_receiver_tick_gen.sv
// Restartable rate divider: one-cycle tick every
// TICK_DIV+1 cycles, realigned by restart.
module tick_gen #(
  parameter logic [27:0] TICK_DIV = 28'd12499999
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  logic [27:0] count;

  assign tick = (count == 28'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= TICK_DIV;
    end else if (restart || tick) begin
      count <= TICK_DIV;
    end else begin
      count <= count - 28'd1;
    end
  end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: times key marks/gaps, collects dots and
// dashes, decodes letters A..H to a 3-bit index.
module morse_receiver
  import morse_defs::*;
#(
  parameter logic [27:0] TICK_DIV  = DEF_TICK_DIV,
  parameter logic [3:0]  DASH_MIN  = DEF_DASH_MIN,
  parameter logic [3:0]  GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic [2:0] sym_count,
  output logic [3:0] pattern
);

  logic    s1, ks, ks_d;
  logic    rise, fall, ks_edge;
  logic    tick;
  logic    [3:0] dur;
  state_t  state;
  lookup_t hit;

  assign rise    = ks & ~ks_d;
  assign fall    = ~ks & ks_d;
  assign ks_edge = rise | fall;
  assign hit     = lookup(sym_count, pattern);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      ks   <= 1'b0;
      ks_d <= 1'b0;
    end else begin
      s1   <= key_in;
      ks   <= s1;
      ks_d <= ks;
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .restart(ks_edge),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dur <= 4'd0;
    end else if (ks_edge) begin
      dur <= 4'd0;
    end else if (tick && dur != 4'd15) begin
      dur <= dur + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      error        <= 1'b0;
      sym_count    <= 3'd0;
      pattern      <= 4'd0;
    end else begin
      letter_valid <= 1'b0;
      error        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= MARK;
        end
        MARK: begin
          if (fall) begin
            unique case (1'b1)
              (dur == 4'd0): begin
                state <= (sym_count != 3'd0) ? SPACE : IDLE;
              end
              (sym_count == 3'd4): begin
                error     <= 1'b1;
                pattern   <= 4'd0;
                sym_count <= 3'd0;
                state     <= IDLE;
              end
              default: begin
                pattern[sym_count[1:0]] <= (dur >= DASH_MIN);
                sym_count <= sym_count + 3'd1;
                state     <= SPACE;
              end
            endcase
          end
        end
        SPACE: begin
          // a rising edge beats a coincident gap tick
          if (rise) begin
            state <= MARK;
          end else if (tick && dur == GAP_TICKS - 4'd1) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          if (hit.hit) begin
            letter       <= hit.index;
            letter_valid <= 1'b1;
          end else begin
            error <= 1'b1;
          end
          pattern   <= 4'd0;
          sym_count <= 3'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Scoreboard bench for morse_receiver with a fast tick
// (TICK_DIV = 3) and directed key sequences.
module tb_morse_receiver;

  logic       clock;
  logic       reset_n;
  logic       key_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       error;
  logic [2:0] sym_count;
  logic [3:0] pattern;

  typedef struct {
    bit       is_err;
    bit [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  morse_receiver #(
    .TICK_DIV (28'd3),
    .DASH_MIN (4'd3),
    .GAP_TICKS(4'd6)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_in      (key_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .error       (error),
    .sym_count   (sym_count),
    .pattern     (pattern)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic dot_gap();
    hold(1'b1, 8);
    hold(1'b0, 8);
  endtask

  task automatic push(input bit is_err, input bit [2:0] idx);
    exp_t e;
    e.is_err = is_err;
    e.idx    = idx;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset_n && (letter_valid || error)) begin
      exp_t e;
      if (letter_valid && error) begin
        checks++;
        errors++;
        $display("FAIL both_high: valid=1 error=1, expected one");
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0d error=%0d, expected none",
                 letter_valid, error);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_is_error", int'(error), int'(e.is_err));
        if (!e.is_err) chk("letter_on_valid", int'(letter), int'(e.idx));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    key_in  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_letter", int'(letter), 0);
    chk("rst_valid", int'(letter_valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_sym_count", int'(sym_count), 0);
    chk("rst_pattern", int'(pattern), 0);
    reset_n = 1'b1;
    hold(1'b0, 4);

    // 1: dot dash -> A
    push(1'b0, 3'd0);
    hold(1'b1, 8);
    hold(1'b0, 12);
    hold(1'b1, 16);
    hold(1'b0, 10);
    chk("t1_pattern", int'(pattern), 4'b0010);
    chk("t1_sym_count", int'(sym_count), 2);
    hold(1'b0, 30);
    chk("t1_sym_after", int'(sym_count), 0);
    chk("t1_letter", int'(letter), 0);

    // 2: four dots -> H
    push(1'b0, 3'd7);
    repeat (4) dot_gap();
    chk("t2_pattern", int'(pattern), 4'b0000);
    chk("t2_sym_count", int'(sym_count), 4);
    hold(1'b0, 32);
    chk("t2_letter", int'(letter), 7);

    // 3: five dots -> overflow error
    push(1'b1, 3'd0);
    repeat (4) dot_gap();
    hold(1'b1, 8);
    hold(1'b0, 6);
    chk("t3_sym_count", int'(sym_count), 0);
    hold(1'b0, 34);
    chk("t3_letter_held", int'(letter), 7);

    // 4: three dashes, unmapped -> error in decode
    push(1'b1, 3'd0);
    repeat (3) begin
      hold(1'b1, 16);
      hold(1'b0, 8);
    end
    chk("t4_pattern", int'(pattern), 4'b0111);
    hold(1'b0, 32);
    chk("t4_letter_held", int'(letter), 7);
    chk("t4_sym_after", int'(sym_count), 0);

    // 5: glitch mark ignored
    hold(1'b1, 2);
    hold(1'b0, 6);
    chk("t5_sym_count", int'(sym_count), 0);
    hold(1'b0, 34);
    chk("t5_letter_held", int'(letter), 7);

    // 6: reset mid-letter, then E
    dot_gap();
    dot_gap();
    chk("t6_sym_before", int'(sym_count), 2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_letter", int'(letter), 0);
    chk("t6_rst_sym", int'(sym_count), 0);
    chk("t6_rst_pattern", int'(pattern), 0);
    chk("t6_rst_valid", int'(letter_valid), 0);
    chk("t6_rst_error", int'(error), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    hold(1'b0, 4);
    push(1'b0, 3'd4);
    hold(1'b1, 8);
    hold(1'b0, 40);
    chk("t6_letter", int'(letter), 4);

    hold(1'b0, 4);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
